// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands summed DIGIT bits per clock, LSB first.
// Define SERIAL_ADDER_SUB_EN to enable the subtract mode selected by the captured sub input.
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_d;
  logic             accept;
  logic             step;
  logic             last;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] b_load;
  logic             seed;
  logic [DIGIT-1:0] dsum;
  logic [DIGIT:0]   chain;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] b_next;
  logic [WIDTH-1:0] sum_next;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtract as a + ~b + 1; carry_out then reads as "no borrow".
  assign b_load = sub ? ~b : b;
  assign seed   = sub ? 1'b1 : carry_in;
`else
  logic unused_sub;
  assign b_load     = b;
  assign seed       = carry_in;
  assign unused_sub = sub;
`endif

  // Next-state and control strobes.
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CNT_W'(N - 1)) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ripple through one digit; chain[DIGIT-1] is the carry into the digit's top bit.
  always_comb begin
    chain    = '0;
    dsum     = '0;
    chain[0] = carry;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      dsum[i]    = a_sh[i] ^ b_sh[i] ^ chain[i];
      chain[i+1] = (a_sh[i] & b_sh[i]) | (chain[i] & (a_sh[i] ^ b_sh[i]));
    end
  end

  generate
    if (N == 1) begin : g_single
      assign a_next   = '0;
      assign b_next   = '0;
      assign sum_next = WIDTH'(dsum);
    end else begin : g_multi
      assign a_next   = {{DIGIT{1'b0}}, a_sh[WIDTH-1:DIGIT]};
      assign b_next   = {{DIGIT{1'b0}}, b_sh[WIDTH-1:DIGIT]};
      assign sum_next = {dsum, sum[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Operand shifters, carry, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh      <= '0;
      b_sh      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      busy <= (state_d == RUN);
      done <= (state_d == DONE);
      if (accept) begin
        a_sh  <= a;
        b_sh  <= b_load;
        carry <= seed;
        cnt   <= '0;
      end else if (step) begin
        a_sh  <= a_next;
        b_sh  <= b_next;
        carry <= chain[DIGIT];
        sum   <= sum_next;
        cnt   <= cnt + CNT_W'(1);
        if (last) begin
          carry_out <= chain[DIGIT];
          overflow  <= chain[DIGIT-1] ^ chain[DIGIT];
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit/1-bit instance and a 16-bit/4-bit instance
// checked against an arithmetic reference model.
module tb_serial_adder;

  localparam int W1 = 8;
  localparam int D1 = 1;
  localparam int N1 = W1 / D1;
  localparam int W2 = 16;
  localparam int D2 = 4;
  localparam int N2 = W2 / D2;

`ifdef SERIAL_ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start1, cin1, sub1, busy1, done1, co1, ov1;
  logic [W1-1:0] a1, b1, sum1;
  logic          start2, cin2, sub2, busy2, done2, co2, ov2;
  logic [W2-1:0] a2, b2, sum2;

  serial_adder #(.WIDTH(W1), .DIGIT(D1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .carry_in(cin1), .sub(sub1),
    .busy(busy1), .done(done1), .sum(sum1), .carry_out(co1), .overflow(ov1)
  );

  serial_adder #(.WIDTH(W2), .DIGIT(D2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .carry_in(cin2), .sub(sub2),
    .busy(busy2), .done(done2), .sum(sum2), .carry_out(co2), .overflow(ov2)
  );

  typedef struct {
    logic [63:0] sum;
    logic        co;
    logic        ov;
    int          cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   bcnt1 = 0;
  int   bcnt2 = 0;
  int   ndone1 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic; overflow from operand/result signs.
  function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                input logic cin, input logic sub,
                                output logic [63:0] s, output logic co, output logic ov);
    logic [63:0] mask, bm, full;
    logic        c;
    mask = (64'd1 << w) - 64'd1;
    bm   = b & mask;
    c    = cin;
    if (SUB_EN && sub) begin
      bm = ~b & mask;
      c  = 1'b1;
    end
    full = (a & mask) + bm + 64'(c);
    s    = full & mask;
    co   = full[w];
    ov   = (a[w-1] == bm[w-1]) && (s[w-1] != a[w-1]);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      bcnt1 = 0;
    end else begin
      if (busy1) bcnt1++;
      else begin
        if (done1) check("busy_len1", 64'(bcnt1), 64'(N1));
        bcnt1 = 0;
      end
      if (done1) begin
        ndone1++;
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done1 at cycle %0d sum %0h", cyc, sum1);
        end else begin
          e = q1.pop_front();
          check("sum1", 64'(sum1), e.sum);
          check("carry_out1", 64'(co1), 64'(e.co));
          check("overflow1", 64'(ov1), 64'(e.ov));
          check("latency1", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      bcnt2 = 0;
    end else begin
      if (busy2) bcnt2++;
      else begin
        if (done2) check("busy_len2", 64'(bcnt2), 64'(N2));
        bcnt2 = 0;
      end
      if (done2) begin
        if (q2.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done2 at cycle %0d sum %0h", cyc, sum2);
        end else begin
          e = q2.pop_front();
          check("sum2", 64'(sum2), e.sum);
          check("carry_out2", 64'(co2), 64'(e.co));
          check("overflow2", 64'(ov2), 64'(e.ov));
          check("latency2", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  // Issue one op; returns #1 into the DONE cycle, where a following call is accepted.
  task automatic op1(input logic [W1-1:0] a, input logic [W1-1:0] b, input logic cin,
                     input logic sub, input bit hold);
    logic [63:0] s;
    logic        co, ov;
    a1 = a; b1 = b; cin1 = cin; sub1 = sub; start1 = 1'b1;
    model(W1, 64'(a), 64'(b), cin, sub, s, co, ov);
    q1.push_back('{sum: s, co: co, ov: ov, cyc: cyc + 1 + N1});
    @(posedge clk); #1;
    if (!hold) start1 = 1'b0;
    repeat (N1) @(posedge clk);
    #1;
  endtask

  task automatic op2(input logic [W2-1:0] a, input logic [W2-1:0] b, input logic cin,
                     input logic sub);
    logic [63:0] s;
    logic        co, ov;
    a2 = a; b2 = b; cin2 = cin; sub2 = sub; start2 = 1'b1;
    model(W2, 64'(a), 64'(b), cin, sub, s, co, ov);
    q2.push_back('{sum: s, co: co, ov: ov, cyc: cyc + 1 + N2});
    @(posedge clk); #1;
    start2 = 1'b0;
    repeat (N2) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst = 1'b1;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; sub2 = 1'b0;
    idle(3);
    check("rst_busy", 64'(busy1), 64'd0);
    check("rst_done", 64'(done1), 64'd0);
    check("rst_sum", 64'(sum1), 64'd0);
    check("rst_carry_out", 64'(co1), 64'd0);
    check("rst_overflow", 64'(ov1), 64'd0);
    rst = 1'b0;
    idle(2);

    // Directed cases, including subtract (model follows the build's SUB_EN).
    op1(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
    idle(2);
    op1(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    op1(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    idle(1);
    op1(8'h10, 8'h20, 1'b0, 1'b1, 1'b0);
    op1(8'h20, 8'h10, 1'b0, 1'b1, 1'b0);
    idle(3);

    // Start pulsed mid-RUN with other operands must be ignored.
    d0 = ndone1;
    a1 = 8'h11; b1 = 8'h22; cin1 = 1'b0; sub1 = 1'b0; start1 = 1'b1;
    begin
      logic [63:0] s;
      logic        co, ov;
      model(W1, 64'h11, 64'h22, 1'b0, 1'b0, s, co, ov);
      q1.push_back('{sum: s, co: co, ov: ov, cyc: cyc + 1 + N1});
    end
    @(posedge clk); #1;
    start1 = 1'b0;
    idle(2);
    a1 = 8'hAA; b1 = 8'h55; cin1 = 1'b1; sub1 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
    repeat (N1 - 3) @(posedge clk);
    #1;
    idle(N1 + 4);
    check("ignored_start_one_done", 64'(ndone1 - d0), 64'd1);

    // Start held high: back-to-back results every N+1 cycles.
    for (int k = 0; k < 5; k++)
      op1(W1'($urandom), W1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    start1 = 1'b0;
    idle(3);

    // Reset during RUN aborts without a done pulse.
    a1 = 8'h33; b1 = 8'h44; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    idle(3);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 64'(busy1), 64'd0);
    check("abort_sum", 64'(sum1), 64'd0);
    check("abort_done", 64'(done1), 64'd0);
    rst = 1'b0;
    idle(N1 + 2);
    op1(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    idle(1);

    // Randomised traffic with random gaps.
    for (int k = 0; k < 30; k++) begin
      op1(W1'($urandom), W1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      idle($urandom_range(0, 2));
    end

    // Wide digit instance.
    op2(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    idle(1);
    op2(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    op2(16'h8000, 16'h8000, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      op2(W2'($urandom), W2'($urandom), 1'($urandom), 1'($urandom));
      idle($urandom_range(0, 2));
    end

    idle(N1 + 4);
    check("drain_q1", 64'(q1.size()), 64'd0);
    check("drain_q2", 64'(q2.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
